// File: rtl/dift_tag_prop_pipe_pkg.sv
// ============================================================================
// Module  : dift_tag_prop_pipe_pkg
// Brief   : Shared DIFT tag-propagation types, including the TPCR layout and opclasses.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dift_tag_prop_pipe_pkg;

  typedef enum logic [1:0] {
    PROP_OR      = 2'd0,
    PROP_AND     = 2'd1,
    PROP_BIT_OR  = 2'd2,
    PROP_BIT_AND = 2'd3
  } dift_prop_mode_e;

  typedef enum logic [3:0] {
    OPC_NONE = 4'd0,
    OPC_LOAD = 4'd1,
    OPC_STOR = 4'd2,
    OPC_CSR  = 4'd3,
    OPC_BRAN = 4'd4,
    OPC_LOG  = 4'd5,
    OPC_ADD  = 4'd6,
    OPC_MUL  = 4'd7,
    OPC_COMP = 4'd8,
    OPC_FPU  = 4'd9,
    OPC_SHFT = 4'd10,
    OPC_XPLP = 4'd11
  } dift_prop_opclass_t;

  localparam int NCLS = 12;

  // The per-class enable and mode are indexed by the opclass encoding.
  typedef struct packed {
    logic                       csr_en;
    logic                       en_shamt;
    logic [NCLS-1:0]            en;
    logic [NCLS-1:0][1:0]       mode;
  } dift_tpcr_t;

endpackage

`default_nettype wire

// File: rtl/dift_tag_prop_policy.sv
// ============================================================================
// Module  : dift_tag_prop_policy
// Brief   : Combinational per-beat tag policy. It is shared with the LSU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dift_tag_prop_policy
  import dift_tag_prop_pipe_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  dift_tpcr_t         tpcr_i,
  input  dift_prop_opclass_t opclass_i,
  input  logic               rega_used_i,
  input  logic               regb_used_i,
  input  logic               regc_used_i,
  input  logic [TAG_W-1:0]   op_a_tag_i,
  input  logic [TAG_W-1:0]   op_b_tag_i,
  input  logic [TAG_W-1:0]   op_c_tag_i,
  output logic [TAG_W-1:0]   tag_o
);

  dift_prop_mode_e  w_mode;
  logic             w_en;
  logic             w_use_b;
  logic             w_use_c;
  logic             w_combine;
  logic [TAG_W-1:0] w_comb;
  logic             w_unused_rega;

  // Operand A always participates in every class that reads operands.
  assign w_unused_rega = rega_used_i;

  assign w_mode = dift_prop_mode_e'(tpcr_i.mode[opclass_i]);
  assign w_en   = tpcr_i.en[opclass_i];

  always_comb begin
    w_use_b   = 1'b0;
    w_use_c   = 1'b0;
    w_combine = 1'b0;
    w_comb    = '0;
    tag_o     = '0;
    case (opclass_i)
      OPC_CSR:            tag_o = tpcr_i.csr_en ? {TAG_W{1'b1}} : '0;
      OPC_LOAD, OPC_STOR: tag_o = op_a_tag_i;
      OPC_SHFT: begin
        w_combine = 1'b1;
        w_use_b   = regb_used_i & tpcr_i.en_shamt;
      end
      OPC_LOG, OPC_ADD, OPC_MUL, OPC_COMP, OPC_FPU: begin
        w_combine = 1'b1;
        w_use_b   = regb_used_i;
      end
      OPC_XPLP: begin
        w_combine = 1'b1;
        w_use_b   = regb_used_i;
        w_use_c   = regb_used_i & regc_used_i;
      end
      default: ;
    endcase

    // Unused operands contribute the identity element of the combining operator.
    case (w_mode)
      PROP_OR:      w_comb = {TAG_W{(|op_a_tag_i) | (w_use_b & (|op_b_tag_i))
                                    | (w_use_c & (|op_c_tag_i))}};
      PROP_AND:     w_comb = {TAG_W{(|op_a_tag_i) & (~w_use_b | (|op_b_tag_i))
                                    & (~w_use_c | (|op_c_tag_i))}};
      PROP_BIT_OR:  w_comb = op_a_tag_i | (w_use_b ? op_b_tag_i : '0)
                             | (w_use_c ? op_c_tag_i : '0);
      PROP_BIT_AND: w_comb = op_a_tag_i & (w_use_b ? op_b_tag_i : {TAG_W{1'b1}})
                             & (w_use_c ? op_c_tag_i : {TAG_W{1'b1}});
      default:      w_comb = '0;
    endcase

    if (w_combine) tag_o = w_comb;
    if (!w_en)     tag_o = '0;
  end

endmodule

`default_nettype wire

// File: rtl/dift_tag_prop_pipe.sv
// ============================================================================
// Module  : dift_tag_prop_pipe
// Brief   : Registered DIFT tag propagation with multi-beat OR accumulation and a taint counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dift_tag_prop_pipe
  import dift_tag_prop_pipe_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  dift_tpcr_t         tpcr_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  dift_prop_opclass_t opclass_i,
  input  logic               rega_used_i,
  input  logic               regb_used_i,
  input  logic               regc_used_i,
  input  logic [TAG_W-1:0]   op_a_tag_i,
  input  logic [TAG_W-1:0]   op_b_tag_i,
  input  logic [TAG_W-1:0]   op_c_tag_i,
  input  logic               multi_i,
  input  logic               last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [TAG_W-1:0]   result_o,
  input  logic               cnt_clr_i,
  output logic [CNT_W-1:0]   taint_cnt_o
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ACCUM = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [TAG_W-1:0] acc_q, acc_d;
  logic [TAG_W-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [TAG_W-1:0] w_beat_tag;
  logic [TAG_W-1:0] w_merged;
  logic             w_accept;
  logic             w_final;
  logic             w_out_fire;

  dift_tag_prop_policy #(
    .TAG_W (TAG_W)
  ) u_policy (
    .tpcr_i      (tpcr_i),
    .opclass_i   (opclass_i),
    .rega_used_i (rega_used_i),
    .regb_used_i (regb_used_i),
    .regc_used_i (regc_used_i),
    .op_a_tag_i  (op_a_tag_i),
    .op_b_tag_i  (op_b_tag_i),
    .op_c_tag_i  (op_c_tag_i),
    .tag_o       (w_beat_tag)
  );

  assign in_ready_o  = !out_valid_q | out_ready_i;
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_final     = !multi_i | last_i;
  assign w_out_fire  = out_valid_q & out_ready_i;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign taint_cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept && !w_final) state_d = S_ACCUM;
      S_ACCUM: if (w_accept && w_final)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulation is always OR so taint from early beats is never dropped.
  always_comb begin
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    w_merged    = (state_q == S_ACCUM) ? (acc_q | w_beat_tag) : w_beat_tag;
    if (out_ready_i) out_valid_d = 1'b0;
    if (w_accept) begin
      if (w_final) begin
        acc_d       = '0;
        result_d    = w_merged;
        out_valid_d = 1'b1;
      end else begin
        acc_d = w_merged;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)
      cnt_d = '0;
    else if (w_out_fire && (|result_q) && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

`default_nettype wire
